// File: rtl/ysyx_25030081_dmem_resp_pkg.sv
// Shared definitions for the data-memory responder and its byte-lane unit.
//   - req_op size codes (funct3 style)
//   - FSM state encoding
//   - base byte-lane masks, shifted into position by the lane unit
package ysyx_25030081_dmem_resp_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/ysyx_25030081_dmem_resp_if.sv
// Load/store bus between the LSU (master) and the data-memory responder (slave).
//   req_*  : valid/ready request channel (wen, byte address, LSB-aligned store data, size op)
//   rsp_*  : valid/ready response channel (extended load data, error flag)
interface ysyx_25030081_dmem_resp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [2:0]            req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_25030081_dmem_lane.sv
// Combinational byte-lane unit.
//   op, addr_lo : size code and low address bits of the access
//   wen         : 1 = store (only B/H/W legal), 0 = load
//   wdata       : LSB-aligned store data
//   rword       : raw 32-bit word read from storage
//   wstrb       : byte write strobes
//   wdata_rep   : store data replicated into every lane of its size
//   rdata_ext   : selected lane(s), sign- or zero-extended
//   op_err      : illegal op for the direction, or misaligned H/W access
module ysyx_25030081_dmem_lane
    import ysyx_25030081_dmem_resp_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        op_err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        wstrb     = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
        op_err    = 1'b0;
        case (op)
            OP_B: begin
                wstrb     = MASK_B << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_H: begin
                op_err    = addr_lo[0];
                wstrb     = MASK_H << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{half_sel[15]}}, half_sel};
            end
            OP_W: begin
                op_err    = (addr_lo != 2'b00);
                wstrb     = MASK_W;
                wdata_rep = wdata;
                rdata_ext = rword;
            end
            // Unsigned sizes exist only for loads.
            OP_BU: begin
                op_err    = wen;
                rdata_ext = {24'b0, byte_sel};
            end
            OP_HU: begin
                op_err    = wen | addr_lo[0];
                rdata_ext = {16'b0, half_sel};
            end
            default: op_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25030081_dmem_resp.sv
// Registered multi-cycle data-memory responder.
//   clk   : rising-edge clock
//   rst   : asynchronous, active-low reset
//   bus   : slave side of the load/store bus (request and response channels)
// One request is accepted in IDLE, held for LATENCY cycles, the array access is
// committed on the edge entering RESP, and the response is held until rsp_ready.
module ysyx_25030081_dmem_resp
    import ysyx_25030081_dmem_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h80000000,
    parameter int                    LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_25030081_dmem_resp_if.slave  bus
);

    localparam int                    IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  wen_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;
    logic [2:0]            op_p0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_idle;
    logic                  accept;
    logic                  do_access;
    logic                  acc_wen;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [2:0]            acc_op;
    logic [ADDR_WIDTH-1:0] off;
    logic                  range_err;
    logic [IDX_W-1:0]      idx;
    logic                  lane_err;
    logic                  acc_err;
    logic [3:0]            wstrb;
    logic [31:0]           wdata_rep;
    logic [31:0]           rdata_ext;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign in_idle = (state == S_IDLE);
    assign accept  = in_idle && bus.req_valid;

    // With LATENCY=1 the access happens on the accept edge itself, so the
    // live request fields are used instead of the not-yet-captured copies.
    assign do_access = ((state == S_WAIT) && (cnt == 4'd0)) || ((LATENCY == 1) && accept);

    always_comb begin
        acc_wen   = in_idle ? bus.req_wen   : wen_p0;
        acc_addr  = in_idle ? bus.req_addr  : addr_p0;
        acc_wdata = in_idle ? bus.req_wdata : wdata_p0;
        acc_op    = in_idle ? bus.req_op    : op_p0;
    end

    // Address below BASE wraps the subtraction, so it is tested separately.
    always_comb begin
        off       = acc_addr - BASE;
        range_err = (acc_addr < BASE) || ((off >> 2) >= DEPTH_A);
        idx       = range_err ? '0 : off[IDX_W+1:2];
    end

    ysyx_25030081_dmem_lane u_lane (
        .op        (acc_op),
        .addr_lo   (acc_addr[1:0]),
        .wen       (acc_wen),
        .wdata     (acc_wdata),
        .rword     (mem[idx]),
        .wstrb     (wstrb),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .op_err    (lane_err)
    );

    assign acc_err       = range_err | lane_err;
    assign mem_we        = rst & do_access & acc_wen & ~acc_err;
    assign rsp_rdata_nxt = (acc_err || acc_wen) ? '0 : rdata_ext;

    // Stage p0: request capture in IDLE
    always_ff @(posedge clk) begin
        if (accept) begin
            wen_p0   <= bus.req_wen;
            addr_p0  <= bus.req_addr;
            wdata_p0 <= bus.req_wdata;
            op_p0    <= bus.req_op;
        end
    end

    // Stage p1: array commit on the edge entering RESP
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (LATENCY == 1) begin
                            state       <= S_RESP;
                            rsp_rdata_q <= rsp_rdata_nxt;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= S_RESP;
                        rsp_rdata_q <= rsp_rdata_nxt;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // rsp_rdata keeps its value after the handshake.
                    if (bus.rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_err_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030081_dmem_resp.sv
// Self-checking bench for ysyx_25030081_dmem_resp: directed cases followed by
// randomized transactions, checked against a byte-addressed reference memory.
module tb_ysyx_25030081_dmem_resp;
    import ysyx_25030081_dmem_resp_pkg::*;

    localparam logic [31:0] BASE    = 32'h80000000;
    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] ref_mem [int];

    ysyx_25030081_dmem_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_25030081_dmem_resp #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .BASE       (BASE),
        .LATENCY    (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, size/sign rules applied directly.
    function automatic void ref_model(input logic wen, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [2:0] op,
                                      output logic err, output logic [31:0] rd);
        int size;
        bit uns;
        int boff;
        logic [31:0] v;
        err  = 1'b0;
        rd   = 32'h0;
        size = 4;
        uns  = 1'b0;
        case (op)
            3'b000: begin size = 1; uns = 1'b0; end
            3'b001: begin size = 2; uns = 1'b0; end
            3'b010: begin size = 4; uns = 1'b0; end
            3'b100: begin size = 1; uns = 1'b1; end
            3'b101: begin size = 2; uns = 1'b1; end
            default: err = 1'b1;
        endcase
        if (wen && uns) err = 1'b1;
        if (addr < BASE) err = 1'b1;
        else if (((addr - BASE) >> 2) >= 32'(DEPTH)) err = 1'b1;
        if ((addr & 32'(size - 1)) != 32'h0) err = 1'b1;
        if (err) return;
        boff = int'(addr - BASE);
        if (wen) begin
            for (int i = 0; i < size; i++) ref_mem[boff + i] = 8'((wdata >> (8 * i)) & 32'hFF);
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[boff + i]) << (8 * i));
            if (!uns && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!uns && size == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endfunction

    // Called at 1 time unit after a rising edge, with the DUT in IDLE.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] op, input int hold,
                       output logic [31:0] got_rd, output logic got_err);
        logic        e_err;
        logic [31:0] e_rd;
        int          n;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_op    = op;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_op    = 3'($urandom);
        ref_model(wen, addr, wdata, op, e_err, e_rd);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(LATENCY));
        got_rd  = bus.rsp_rdata;
        got_err = bus.rsp_err;
        check("rsp_err", 32'(got_err), 32'(e_err));
        check("rsp_rdata", got_rd, e_rd);
        for (int h = 0; h < hold; h++) begin
            // A competing store to word 0 that must be ignored outside IDLE.
            bus.req_valid = 1'b1;
            bus.req_wen   = 1'b1;
            bus.req_op    = OP_W;
            bus.req_addr  = BASE;
            bus.req_wdata = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", bus.rsp_rdata, e_rd);
            check("hold_err", 32'(bus.rsp_err), 32'(e_err));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check("post_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_err", 32'(bus.rsp_err), 32'd0);
        check("post_rdata_hold", bus.rsp_rdata, e_rd);
        check("post_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          sel;

        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_op    = 3'b000;
        bus.rsp_ready = 1'b0;

        #3 rst = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Give the first 16 words known contents.
        for (int w = 0; w < 16; w++) txn(1'b1, BASE + 32'(4 * w), $urandom, OP_W, 0, rd, er);

        txn(1'b1, BASE + 32'h10, 32'hDEADBEEF, OP_W, 0, rd, er);
        check("st_w_err", 32'(er), 32'd0);
        txn(1'b0, BASE + 32'h10, 32'h0, OP_W, 0, rd, er);
        check("ld_w", rd, 32'hDEADBEEF);

        txn(1'b1, BASE + 32'h20, 32'h80FF7F01, OP_W, 0, rd, er);
        txn(1'b0, BASE + 32'h23, 32'h0, OP_B, 0, rd, er);
        check("ld_b", rd, 32'hFFFFFF80);
        txn(1'b0, BASE + 32'h23, 32'h0, OP_BU, 0, rd, er);
        check("ld_bu", rd, 32'h00000080);
        txn(1'b0, BASE + 32'h22, 32'h0, OP_H, 0, rd, er);
        check("ld_h", rd, 32'hFFFF80FF);
        txn(1'b0, BASE + 32'h20, 32'h0, OP_HU, 0, rd, er);
        check("ld_hu", rd, 32'h00007F01);

        txn(1'b1, BASE + 32'h22, 32'h123456AA, OP_B, 0, rd, er);
        txn(1'b0, BASE + 32'h20, 32'h0, OP_W, 0, rd, er);
        check("partial_st", rd, 32'h80AA7F01);

        txn(1'b0, BASE + 32'h21, 32'h0, OP_W, 0, rd, er);
        check("err_ld_w_mis", 32'(er), 32'd1);
        txn(1'b0, BASE + 32'h01, 32'h0, OP_H, 0, rd, er);
        check("err_ld_h_mis", 32'(er), 32'd1);
        txn(1'b1, 32'h7FFFFFFC, 32'hCAFEF00D, OP_W, 0, rd, er);
        check("err_st_low", 32'(er), 32'd1);
        txn(1'b0, BASE + 32'(4 * DEPTH), 32'h0, OP_W, 0, rd, er);
        check("err_ld_high", 32'(er), 32'd1);
        check("err_ld_high_rd", rd, 32'h0);
        txn(1'b1, BASE + 32'h20, 32'h55555555, OP_BU, 0, rd, er);
        check("err_st_bu", 32'(er), 32'd1);
        txn(1'b0, BASE + 32'h20, 32'h0, OP_W, 0, rd, er);
        check("reload_after_err", rd, 32'h80AA7F01);

        // Backpressure with a competing request during RESP.
        txn(1'b0, BASE + 32'h10, 32'h0, OP_W, 5, rd, er);
        check("bp_rdata", rd, 32'hDEADBEEF);
        txn(1'b0, BASE, 32'h0, OP_W, 0, rd, er);

        // Reset during WAIT of a store.
        txn(1'b1, BASE + 32'h30, 32'h0, OP_W, 0, rd, er);
        txn(1'b0, BASE + 32'h10, 32'h0, OP_W, 0, rd, er);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = BASE + 32'h30;
        bus.req_wdata = 32'h12345678;
        bus.req_op    = OP_W;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("mid_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("mid_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, BASE + 32'h30, 32'h0, OP_W, 0, rd, er);
        check("mid_rst_no_write", rd, 32'h0);

        // Randomized traffic over the known region plus out-of-range probes.
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = BASE + 32'($urandom_range(0, 63));
            else if (sel == 8) a = BASE - 32'($urandom_range(1, 8));
            else               a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
            txn(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
